fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the pipelined MIPS CPU: the initiator side of the instruction-memory read interface. Holds the program counter, drives the fetch address to the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for the decode stage. Handles decode-stage stalls and branch/jump redirects under delayed-branch semantics, where the delay-slot instruction always proceeds.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset; base of instruction memory.
- IM_WORDS, 4096, instruction memory depth in 32-bit words; used only by the bound check.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  from hazard unit; freezes PC and IF/ID.
- redirect  in  1  decode-stage branch taken / j / jal / jr.
- redirect_pc  in  32  target for redirect.
- im_addr  out  32  fetch address, equal to the current PC register.
- im_instr  in  32  combinational instruction word for im_addr.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC of instr_d.
- pc8_d  out  32  pc_d + 8, the link value for jal/jalr.
- valid_d  out  1  IF/ID holds a real fetched instruction.
- fetch_cnt  out  32  count of instructions accepted into IF/ID.
- fetch_err_d  out  1  IF/ID instruction came from an illegal address; see Configuration.

## Operation
- The PC register drives im_addr directly, with no registering.
- Next-PC priority per edge: reset, then stall (hold), then redirect (redirect_pc), then PC + 4.
- Advance edge (no reset, no stall):
  - instr_d ← im_instr, pc_d ← PC, pc8_d ← PC + 8.
  - valid_d ← 1, fetch_cnt ← fetch_cnt + 1.
- Redirect does not flush IF/ID. The word fetched in the same cycle as the redirect is the delay slot and is captured normally.
- Stall with redirect asserted: the redirect is ignored. The stalled decode stage re-presents it on a later cycle.
- Arithmetic is mod 2^32: PC + 4 and PC + 8 wrap, and fetch_cnt wraps from 0xFFFF_FFFF to 0.
- redirect_pc is used unmodified, with no alignment masking.

## Timing
- Reset values:
  - PC = RESET_PC, so im_addr = 0x0000_3000 in the cycle after reset.
  - instr_d = 0, pc_d = 0, pc8_d = 0, valid_d = 0, fetch_cnt = 0, fetch_err_d = 0.
- Latency: a word on im_instr appears on instr_d one edge later. A redirect takes effect on im_addr one edge after it is sampled.
- The first instruction at RESET_PC appears on instr_d one edge after reset is released.
- Reset mid-operation (during a stall or redirect) wins unconditionally on that edge.
- Stall held for N cycles: all outputs are constant for N cycles and fetch_cnt does not increment.

## Configuration
- FETCH_BOUND_CHECK_EN defined:
  - On an advance edge, if PC[1:0] ≠ 0, PC < RESET_PC, or PC ≥ RESET_PC + 4·IM_WORDS, then instr_d ← 0 (nop) and fetch_err_d ← 1.
  - pc_d, valid_d and fetch_cnt still update.
  - Otherwise fetch_err_d ← 0.
- FETCH_BOUND_CHECK_EN undefined: fetch_err_d is constant 0 and im_instr is always captured.

## Test plan
- Reset held 2 cycles, then released with IM returning 0x3C01_1234 at 0x3000:
  - im_addr = 0x3000 after reset.
  - Next edge: instr_d = 0x3C01_1234, pc_d = 0x3000, pc8_d = 0x3008, valid_d = 1, fetch_cnt = 1, im_addr = 0x3004.
- Sequential run of 5 edges from 0x3000: im_addr = 0x3014, pc_d = 0x3010, fetch_cnt = 5.
- Redirect to 0x3040 while PC = 0x3008:
  - Next edge: pc_d = 0x3008 (delay slot captured) and im_addr = 0x3040.
  - Following edge: pc_d = 0x3040.
- Stall 3 cycles with redirect = 1, redirect_pc = 0x3100:
  - All outputs are unchanged.
  - After stall drops and redirect persists 1 cycle, im_addr = 0x3100.
- Reset asserted simultaneously with redirect: im_addr = 0x3000, valid_d = 0, fetch_cnt = 0.
- With FETCH_BOUND_CHECK_EN, redirect to 0x3002 and then to 0x7000: each of the next advance edges gives instr_d = 0 and fetch_err_d = 1. Without the macro, fetch_err_d stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit: PC register, instruction-memory fetch and IF/ID capture with |
// | stall and delayed-branch redirect. Option macro: FETCH_BOUND_CHECK_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic [31:0] fetch_cnt,
  output logic        fetch_err_d
);

  logic [31:0] pc_q,       pc_nx;
  logic [31:0] if_instr_q, if_instr_nx;
  logic [31:0] if_pc_q,    if_pc_nx;
  logic [31:0] if_pc8_q,   if_pc8_nx;
  logic        if_valid_q, if_valid_nx;
  logic [31:0] cnt_q,      cnt_nx;
  logic        err_q,      err_nx;
  logic        w_bad_fetch;

`ifdef FETCH_BOUND_CHECK_EN
  // 33-bit limit so the upper bound cannot wrap for memories ending at 2^32.
  localparam logic [32:0] c_im_end = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  always_comb begin
    w_bad_fetch = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) ||
                  ({1'b0, pc_q} >= c_im_end);
  end
`else
  always_comb begin
    w_bad_fetch = 1'b0;
  end
`endif

  always_comb begin
    pc_nx       = pc_q;
    if_instr_nx = if_instr_q;
    if_pc_nx    = if_pc_q;
    if_pc8_nx   = if_pc8_q;
    if_valid_nx = if_valid_q;
    cnt_nx      = cnt_q;
    err_nx      = err_q;
    if (!stall) begin
      // The word fetched alongside a redirect is the delay slot: captured, never flushed.
      pc_nx       = redirect ? redirect_pc : pc_q + 32'd4;
      if_instr_nx = w_bad_fetch ? 32'd0 : im_instr;
      if_pc_nx    = pc_q;
      if_pc8_nx   = pc_q + 32'd8;
      if_valid_nx = 1'b1;
      cnt_nx      = cnt_q + 32'd1;
      err_nx      = w_bad_fetch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_instr_q <= 32'd0;
      if_pc_q    <= 32'd0;
      if_pc8_q   <= 32'd0;
      if_valid_q <= 1'b0;
      cnt_q      <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_nx;
      if_instr_q <= if_instr_nx;
      if_pc_q    <= if_pc_nx;
      if_pc8_q   <= if_pc8_nx;
      if_valid_q <= if_valid_nx;
      cnt_q      <= cnt_nx;
      err_q      <= err_nx;
    end
  end

  assign im_addr     = pc_q;
  assign instr_d     = if_instr_q;
  assign pc_d        = if_pc_q;
  assign pc8_d       = if_pc8_q;
  assign valid_d     = if_valid_q;
  assign fetch_cnt   = cnt_q;
  assign fetch_err_d = err_q;

endmodule
`default_nettype wire
